// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and constants for the RV32I decode/execute boundary.
//   XLEN              datapath / operand width
//   CTRL_W            width of the packed control bundle
//   REG_X0            index of the hard-wired zero register
//   ctrl_t            packed control bundle; the first field listed is the MSB:
//                     alu_op[3:0], alu_src, mem_read, mem_write, reg_write,
//                     result_src[1:0], branch, jump
//   ctrl_mem_read()   extracts mem_read from a flat control vector
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 12;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic       branch;
        logic       jump;
    } ctrl_t;

    // mem_read sits directly below alu_op[3:0] and alu_src.
    localparam int CTRL_MEM_READ_BIT = CTRL_W - 4 - 2;

    function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_READ_BIT];
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// operand_bypass: selects the value captured into the ID/EX slot for one source
// operand.
//   rs        source register index
//   rf_data   register file read data (stale when write-back targets rs this cycle)
//   wb_we, wb_rd, wb_data     write-back port (same as register file WE3/A3/WD3)
//   mem_we, mem_rd, mem_data  EX/MEM result (used only with ID_EX_FORWARDING_EN)
//   operand   selected operand value
// Priority: x0 -> 0, then EX/MEM (ID_EX_FORWARDING_EN only), then write-back,
// then register file data.
module operand_bypass
    import rv32i_pkg::*;
(
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mem_we,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] operand
);

`ifdef ID_EX_FORWARDING_EN
    always_comb begin
        operand = rf_data;
        if (rs == REG_X0)
            operand = '0;
        else if (mem_we && mem_rd == rs)
            operand = mem_data;
        else if (wb_we && wb_rd == rs)
            operand = wb_data;
    end
`else
    // The EX/MEM port is part of the interface in both builds but ignored here.
    logic unused_mem;
    assign unused_mem = ^{mem_we, mem_rd, mem_data};

    always_comb begin
        operand = rf_data;
        if (rs == REG_X0)
            operand = '0;
        else if (wb_we && wb_rd == rs)
            operand = wb_data;
    end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode->execute pipeline register of the RV32I core.
// Holds one instruction slot with a valid/ready handshake, flush, and load-use
// bubble insertion. Operands are resolved once, at capture, through
// operand_bypass (write-back fix-up always; EX/MEM bypass with
// ID_EX_FORWARDING_EN defined).
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   id_valid / id_ready      decode-side handshake
//   id_pc, id_imm, id_rs1, id_rs2, id_rd, id_ctrl   decoded fields
//   rf_rd1, rf_rd2           register file read data
//   flush                    squash the slot
//   wb_we, wb_rd, wb_data    write-back port
//   mem_we, mem_rd, mem_data EX/MEM result
//   ex_valid / ex_ready      execute-side handshake
//   ex_pc, ex_imm, ex_op1, ex_op2, ex_rs1, ex_rs2, ex_rd, ex_ctrl   slot contents
//   hazard_stall             load-use bubble being inserted this cycle
// Configuration macro: ID_EX_FORWARDING_EN.
module id_ex_stage
    import rv32i_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              mem_we,
    input  logic [4:0]        mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              hazard_stall
);

    logic            adv;
    logic            load;
    logic [XLEN-1:0] op1_p0;
    logic [XLEN-1:0] op2_p0;

    assign adv = !ex_valid || ex_ready;

    assign hazard_stall = ex_valid && ctrl_mem_read(ex_ctrl) && (ex_rd != REG_X0) &&
                          id_valid && (id_rs1 == ex_rd || id_rs2 == ex_rd);

    // A flushed decode slot is not consumed, so it must not see ready either.
    assign id_ready = !rst && adv && !hazard_stall && !flush;
    assign load     = id_valid && id_ready;

    operand_bypass u_op1 (
        .rs       (id_rs1),
        .rf_data  (rf_rd1),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .operand  (op1_p0)
    );

    operand_bypass u_op2 (
        .rs       (id_rs2),
        .rf_data  (rf_rd2),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .operand  (op2_p0)
    );

    // ---- decode -> execute boundary ----
    // Bubble (hazard with adv) and drain both fall into the final branch: neither
    // loads, and both clear valid while the fields hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_imm   <= '0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_ctrl  <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (load) begin
            ex_valid <= 1'b1;
            ex_pc    <= id_pc;
            ex_imm   <= id_imm;
            ex_op1   <= op1_p0;
            ex_op2   <= op2_p0;
            ex_rs1   <= id_rs1;
            ex_rs2   <= id_rs2;
            ex_rd    <= id_rd;
            ex_ctrl  <= id_ctrl;
        end else if (adv) begin
            ex_valid <= 1'b0;
        end
    end

endmodule
